// File: rtl/regfile_sb_pkg.sv
// Shared constants and the bypass-select rule for the register file and forwarding logic.
package regfile_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_ZERO_REG = 1;

  // A read sees the in-flight write data unless it targets the hardwired zero register.
  function automatic logic bypass_sel(input logic        we,
                                      input logic [31:0] waddr,
                                      input logic [31:0] raddr,
                                      input logic        zero_reg);
    return we && (waddr == raddr) && !(zero_reg && (raddr == 32'd0));
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Write, read and scoreboard signals between the decode/writeback side and the register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_a;
  logic [WIDTH-1:0]  rdata_b;
  logic              mark;
  logic [ADDR_W-1:0] mark_addr;
  logic              busy_a;
  logic              busy_b;
  logic [DEPTH-1:0]  busy_vec;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, mark, mark_addr,
    input  rdata_a, rdata_b, busy_a, busy_b, busy_vec
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, mark, mark_addr,
    output rdata_a, rdata_b, busy_a, busy_b, busy_vec
  );

endinterface

// File: rtl/regfile_sb_en_reg.sv
// Single storage register with synchronous clear and load enable.
module en_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (clr) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-through bypass and a per-register busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic         clk,
  input  logic         clr,
  regfile_sb_if.slave  bus
);

  localparam int   ADDR_W = $clog2(DEPTH);
  localparam logic ZR     = (ZERO_REG != 0);

  logic [WIDTH-1:0] reg_val [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Storage: register 0 collapses to a constant when hardwired to zero.
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (ZR && (i == 0)) begin : g_zero
      assign reg_val[i] = '0;
    end else begin : g_store
      logic wr_en;
      assign wr_en = bus.we && (bus.waddr == ADDR_W'(i));
      en_reg #(.WIDTH(WIDTH)) u_reg (
        .clk (clk),
        .clr (clr),
        .en  (wr_en),
        .d   (bus.wdata),
        .q   (reg_val[i])
      );
    end
  end

  // A returning write clears busy; a new reservation in the same cycle takes priority.
  always_comb begin
    busy_d = busy_q;
    if (bus.we)   busy_d[bus.waddr]     = 1'b0;
    if (bus.mark) busy_d[bus.mark_addr] = 1'b1;
    if (ZR)       busy_d[0]             = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  logic byp_a;
  logic byp_b;

  always_comb begin
    byp_a = bypass_sel(bus.we, 32'(bus.waddr), 32'(bus.raddr_a), ZR);
    byp_b = bypass_sel(bus.we, 32'(bus.waddr), 32'(bus.raddr_b), ZR);
  end

  assign bus.rdata_a  = byp_a ? bus.wdata : reg_val[bus.raddr_a];
  assign bus.rdata_b  = byp_b ? bus.wdata : reg_val[bus.raddr_b];
  assign bus.busy_a   = busy_q[bus.raddr_a] && !(bus.we && (bus.waddr == bus.raddr_a));
  assign bus.busy_b   = busy_q[bus.raddr_b] && !(bus.we && (bus.waddr == bus.raddr_b));
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, read/write, bypass, zero register and scoreboard.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic clr;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(32), .DEPTH(32)) bus ();

  regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.mark = 1'b0;
    bus.waddr = '0; bus.wdata = '0; bus.mark_addr = '0;
  endtask

  initial begin
    idle();
    bus.raddr_a = '0; bus.raddr_b = '0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    #1;
    chk("rst_busy_vec", 64'(bus.busy_vec), 64'h0);
    for (int i = 0; i < 32; i += 5) begin
      bus.raddr_a = 5'(i); bus.raddr_b = 5'(31 - i); #1;
      chk("rst_rdata_a", 64'(bus.rdata_a), 64'h0);
      chk("rst_rdata_b", 64'(bus.rdata_b), 64'h0);
      chk("rst_busy_a", 64'(bus.busy_a), 64'h0);
    end

    // Write r5, then clear while also trying to write and mark.
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
    step();
    idle(); bus.raddr_a = 5'd5; #1;
    chk("r5_written", 64'(bus.rdata_a), 64'hDEADBEEF);
    clr = 1'b1;
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h1111_2222;
    bus.mark = 1'b1; bus.mark_addr = 5'd8;
    step();
    clr = 1'b0; idle(); #1;
    chk("clr_r5", 64'(bus.rdata_a), 64'h0);
    chk("clr_busy_vec", 64'(bus.busy_vec), 64'h0);

    // Plain write then read on both ports.
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h12345678;
    step();
    idle(); bus.raddr_a = 5'd7; bus.raddr_b = 5'd7; #1;
    chk("r7_port_a", 64'(bus.rdata_a), 64'h12345678);
    chk("r7_port_b", 64'(bus.rdata_b), 64'h12345678);

    // Bypass: old value visible before the write cycle, new data during it.
    bus.raddr_a = 5'd9; #1;
    chk("r9_old", 64'(bus.rdata_a), 64'h0);
    step();
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'hA5A5A5A5;
    bus.raddr_a = 5'd7; bus.raddr_b = 5'd9; #1;
    chk("byp_rdata_b", 64'(bus.rdata_b), 64'hA5A5A5A5);
    chk("byp_other_a", 64'(bus.rdata_a), 64'h12345678);
    step();
    idle(); #1;
    chk("r9_stored", 64'(bus.rdata_b), 64'hA5A5A5A5);

    // Zero register ignores writes and marks.
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
    bus.mark = 1'b1; bus.mark_addr = 5'd0;
    bus.raddr_a = 5'd0; #1;
    chk("r0_no_bypass", 64'(bus.rdata_a), 64'h0);
    step();
    idle(); #1;
    chk("r0_rdata", 64'(bus.rdata_a), 64'h0);
    chk("r0_busy_vec", 64'(bus.busy_vec), 64'h0);
    step();
    chk("r0_rdata_later", 64'(bus.rdata_a), 64'h0);
    chk("r0_busy_a", 64'(bus.busy_a), 64'h0);

    // Scoreboard on r3.
    bus.raddr_a = 5'd3;
    bus.mark = 1'b1; bus.mark_addr = 5'd3; #1;
    chk("sb_mark_same_cycle", 64'(bus.busy_a), 64'h0);
    step();
    idle(); #1;
    chk("sb_busy_a", 64'(bus.busy_a), 64'h1);
    chk("sb_busy_vec", 64'(bus.busy_vec), 64'h8);
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h55; #1;
    chk("sb_ret_busy_a", 64'(bus.busy_a), 64'h0);
    chk("sb_ret_rdata_a", 64'(bus.rdata_a), 64'h55);
    step();
    idle(); #1;
    chk("sb_cleared", 64'(bus.busy_vec), 64'h0);
    chk("sb_r3_stored", 64'(bus.rdata_a), 64'h55);

    // Mark and write to the same register: mark wins, data still stored.
    bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h44;
    bus.mark = 1'b1; bus.mark_addr = 5'd4;
    step();
    idle(); bus.raddr_a = 5'd4; #1;
    chk("mw_r4_data", 64'(bus.rdata_a), 64'h44);
    chk("mw_busy_vec", 64'(bus.busy_vec), 64'h10);

    // Make r6 busy too, then mark r4 again while r6's result returns.
    bus.mark = 1'b1; bus.mark_addr = 5'd6;
    step();
    idle(); #1;
    chk("r4_r6_busy", 64'(bus.busy_vec), 64'h50);
    bus.mark = 1'b1; bus.mark_addr = 5'd4;
    bus.we = 1'b1; bus.waddr = 5'd6; bus.wdata = 32'h66;
    bus.raddr_a = 5'd4; bus.raddr_b = 5'd6; #1;
    chk("split_busy_a", 64'(bus.busy_a), 64'h1);
    chk("split_busy_b", 64'(bus.busy_b), 64'h0);
    step();
    idle(); #1;
    chk("split_busy_vec", 64'(bus.busy_vec), 64'h10);
    chk("split_r6_data", 64'(bus.rdata_b), 64'h66);
    chk("split_r4_data", 64'(bus.rdata_a), 64'h44);

    // Returning write for r4 clears the last busy bit.
    bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h4444;
    step();
    idle(); #1;
    chk("final_busy_vec", 64'(bus.busy_vec), 64'h0);
    chk("final_r4_data", 64'(bus.rdata_a), 64'h4444);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file with `DEPTH` registers of `WIDTH` bits.
- One synchronous write port and two combinational read ports.
- Write-through bypass: a read of the address being written returns the new data in the same cycle.
- Per-register busy scoreboard, so the CPU decode stage can stall on results pending from multicycle units (mult/div).
- Register 0 is optionally hardwired to zero.
- Successor to the fixed 32-bit enable/clear register; it is the storage and hazard-tracking core of the CPU datapath.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; power of two, at least 2.
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy.
- ADDR_W, $clog2(DEPTH), address width; localparam, not overridable.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- clr  in  1  synchronous active-high reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- raddr_a  in  ADDR_W  read port A address.
- raddr_b  in  ADDR_W  read port B address.
- rdata_a  out  WIDTH  read port A data (combinational).
- rdata_b  out  WIDTH  read port B data (combinational).
- mark  in  1  set the busy bit of mark_addr (an instruction issued to a multicycle unit).
- mark_addr  in  ADDR_W  destination register being reserved.
- busy_a  out  1  busy bit for raddr_a, after bypass rules.
- busy_b  out  1  busy bit for raddr_b, after bypass rules.
- busy_vec  out  DEPTH  raw registered busy bits, for debug and the stall unit.

Behaviour:
- Clock and reset
  - Single clock `clk`; reset `clr` is synchronous and active-high.
  - On a `clk` edge with `clr`=1: all registers become 0 and `busy_vec` becomes all 0s.
  - `clr` overrides `we` and `mark` in the same cycle.
  - After reset, `rdata_a`/`rdata_b` are 0 for every address and `busy_a`/`busy_b` are 0.
- Write
  - On a `clk` edge with `we`=1 and `clr`=0: `reg[waddr]` <= `wdata`.
  - Latency is 1 cycle to storage, 0 cycles to readers through the bypass.
- Read
  - `rdata_x` = `wdata` if `we`=1, `waddr`=`raddr_x`, and not (ZERO_REG=1 and `raddr_x`=0).
  - Otherwise `rdata_x` = `reg[raddr_x]`.
  - Both ports are independent; the same address on both ports is legal.
- Zero register (ZERO_REG=1)
  - Storage for address 0 is not instantiated or is constant 0.
  - A write to address 0 has no effect.
  - `mark` with `mark_addr`=0 has no effect.
  - `busy_vec[0]` is always 0.
- Scoreboard (per register, on the clock edge)
  - `mark`=1 sets `busy[mark_addr]`.
  - `we`=1 clears `busy[waddr]`.
  - `mark` and `we` to the same address in the same cycle: mark wins, busy=1. This covers a new producer issued as the old result returns.
  - `mark` and `we` to different addresses: both take effect.
  - `we` to a non-busy register: normal write, busy stays 0.
  - `mark` to an already-busy register: stays 1, with no count. There is one outstanding producer per register; the stall unit guarantees this.
- Busy outputs
  - `busy_x` = `busy[raddr_x]` AND NOT (`we` AND `waddr`=`raddr_x`). The returning write is bypassed, so it is not a hazard.
  - A `mark` in the current cycle does not affect `busy_x` until the next cycle.
- Reset mid-operation
  - Pending busy bits are discarded.
  - No write completes in the `clr` cycle.

Decomposition:
- Package `regfile_pkg` holds:
  - default WIDTH/DEPTH constants;
  - the ZERO_REG default;
  - a function computing the bypass-select condition, shared with the future forwarding unit.
- One sub-module: `en_reg`, a WIDTH-parametrised register with synchronous `clr` and `en`.
  - Instantiated DEPTH times (DEPTH-1 when ZERO_REG=1) via generate.
  - Busy bits are a plain DEPTH-bit vector in the top module.

Test Plan:
- Reset: `clr`=1 for one cycle after writing 0xDEADBEEF to r5 -> `rdata_a` for r5 = 0, `busy_vec` = 0.
- Write/read: write 0x12345678 to r7; next cycle `raddr_a`=7, `raddr_b`=7 -> both ports read 0x12345678.
- Bypass: `we`=1, `waddr`=9, `wdata`=0xA5A5A5A5, `raddr_b`=9 in the same cycle -> `rdata_b`=0xA5A5A5A5 combinationally. Old value of r9 (0x0) on port A with `raddr_a`=9 one cycle earlier.
- Zero register: write 0xFFFFFFFF to r0 and `mark` r0 -> `rdata_a`=0 and `busy_vec[0]`=0 on all subsequent cycles.
- Scoreboard sequence (`raddr_a`=3 throughout):
  - `mark` r3 -> `busy_a`=1 from the next cycle.
  - `we` r3 with 0x55 -> `busy_a`=0 in that cycle with `rdata_a`=0x55; `busy_vec[3]`=0 the next cycle.
- Simultaneous mark and write: `mark` r4 and `we` r4 in the same cycle -> r4 holds the written data and `busy_vec[4]`=1 the next cycle. Separately, `mark` r4 with `we` r6 -> `busy_vec[4]`=1 and `busy_vec[6]`=0.
